reg_file_wb: RTL

Register file with write-back staging for the MIPS datapath. Sits directly downstream of the 5-bit destination-register select mux: consumes the selected write register number (rt for I-type, rd for R-type, custom target for swi, $ra for link), the write-back data and the write enable. Provides two combinational read ports to decode. Write-through bypass means decode sees a value written in the same cycle without extra forwarding logic.

---
 rtl/mips_pkg.sv | 13 +
 rtl/reg_read_port.sv | 26 ++
 rtl/reg_file_wb.sv | 72 +++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register numbers and default widths used by
// the destination-select mux, decode and the register file.
package mips_pkg;

    localparam int unsigned REG_ADDR_W     = 5;
    localparam int unsigned NUM_REGS       = 32;
    localparam int unsigned DATA_W_DEFAULT = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage : mips_pkg

// File: rtl/reg_read_port.sv
// One combinational register-file read port: r0 forced to zero, same-cycle
// write bypass, otherwise the array entry.
module reg_read_port
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic [REG_ADDR_W-1:0] read_reg,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [DATA_W-1:0]     regs [NUM_REGS],
    output logic [DATA_W-1:0]     read_data
);

    // reg_write gates the compare so an undriven write_reg cannot leak through
    always_comb begin
        read_data = regs[read_reg];
        if (read_reg == REG_ZERO) begin
            read_data = '0;
        end else if (reg_write && (write_reg == read_reg)) begin
            read_data = write_data;
        end
    end

endmodule : reg_read_port

// File: rtl/reg_file_wb.sv
// 32-entry MIPS register file with two bypassed read ports and a registered
// write-back record for the hazard unit and trace.
module reg_file_wb
    import mips_pkg::*;
#(
    parameter int unsigned        DATA_W  = DATA_W_DEFAULT,
    parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(32'h0000_03FC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [REG_ADDR_W-1:0] read_reg_1,
    input  logic [REG_ADDR_W-1:0] read_reg_2,
    output logic [DATA_W-1:0]     read_data_1,
    output logic [DATA_W-1:0]     read_data_2,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_reg,
    output logic [DATA_W-1:0]     wb_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              commit_c;

    assign commit_c = reg_write && (write_reg != REG_ZERO);

    // Register array; r29 comes out of reset holding the initial stack pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (REG_ADDR_W'(i) == REG_SP) ? SP_INIT : '0;
            end
        end else if (commit_c) begin
            regs[write_reg] <= write_data;
        end
    end

    // Write-back record: valid pulses per commit, reg/data hold between commits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_reg   <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= commit_c;
            if (commit_c) begin
                wb_reg  <= write_reg;
                wb_data <= write_data;
            end
        end
    end

    reg_read_port #(.DATA_W(DATA_W)) u_read_port_1 (
        .read_reg   (read_reg_1),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .regs       (regs),
        .read_data  (read_data_1)
    );

    reg_read_port #(.DATA_W(DATA_W)) u_read_port_2 (
        .read_reg   (read_reg_2),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .regs       (regs),
        .read_data  (read_data_2)
    );

endmodule : reg_file_wb
